// File: rtl/cpu_dbg_pkg.sv
// Shared debug-path definitions: sequencer state encoding, timing defaults, word width.
package cpu_dbg_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned DB_CYCLES_DEF = 1000000;
    localparam int unsigned RUN_DIV_DEF   = 25000000;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2,
        ST_BRK  = 2'd3
    } step_state_e;

endpackage

// File: rtl/key_debounce.sv
// Button conditioner: two-flop synchronizer, stable-level debounce, one-cycle press pulse.
module key_debounce
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic resetn,
    input  logic key,
    output logic press
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts consecutive samples that disagree with the accepted level
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU execution sequencer: step/run/breakpoint clock-enable generation and loader reset hold.
// Optional feature macro: BREAKPOINT_EN (breakpoint compare and BRK state).
module cpu_step_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned RUN_DIV   = RUN_DIV_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              key_step,
    input  logic              key_run,
    input  logic              load_busy,
    input  logic [WORD_W-1:0] pc,
    input  logic [WORD_W-1:0] bp_addr,
    input  logic              bp_valid,
    output logic              cpu_ce,
    output logic              cpu_rst_n,
    output logic [1:0]        state,
    output logic              halted,
    output logic [WORD_W-1:0] step_cnt
);

    localparam int unsigned DIV_W = $clog2(RUN_DIV);

    logic              step_p;
    logic              run_p;
    logic              bp_hit;
    step_state_e       state_q;
    logic              ce_q;
    logic              rst_n_q;
    logic              halted_q;
    logic [WORD_W-1:0] cnt_q;
    logic [DIV_W-1:0]  div_q;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk    (clk),
        .resetn (resetn),
        .key    (key_step),
        .press  (step_p)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk    (clk),
        .resetn (resetn),
        .key    (key_run),
        .press  (run_p)
    );

`ifdef BREAKPOINT_EN
    // Compare one cycle after the enable pulse so pc already holds the new address.
    logic chk_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) chk_q <= 1'b0;
        else         chk_q <= ce_q;
    end

    assign bp_hit = chk_q && bp_valid && (pc == bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_LOAD;
            ce_q     <= 1'b0;
            rst_n_q  <= 1'b0;
            halted_q <= 1'b0;
            cnt_q    <= '0;
            div_q    <= '0;
        end else begin
            ce_q <= 1'b0;
            if (ce_q) cnt_q <= cnt_q + WORD_W'(1);
            if (load_busy) begin
                state_q  <= ST_LOAD;
                rst_n_q  <= 1'b0;
                halted_q <= 1'b0;
                cnt_q    <= '0;
                div_q    <= '0;
            end else begin
                unique case (state_q)
                    ST_LOAD: begin
                        state_q <= ST_IDLE;
                        rst_n_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                    ST_IDLE: begin
                        if (bp_hit) begin
                            state_q  <= ST_BRK;
                            halted_q <= 1'b1;
                        end else if (run_p) begin
                            state_q <= ST_RUN;
                            div_q   <= '0;
                        end else if (step_p) begin
                            ce_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (bp_hit) begin
                            state_q  <= ST_BRK;
                            halted_q <= 1'b1;
                        end else if (run_p) begin
                            state_q <= ST_IDLE;
                        end else if (div_q == DIV_W'(RUN_DIV - 1)) begin
                            ce_q  <= 1'b1;
                            div_q <= '0;
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                    ST_BRK: begin
                        if (run_p) begin
                            state_q  <= ST_RUN;
                            halted_q <= 1'b0;
                            div_q    <= '0;
                        end else if (step_p) begin
                            state_q  <= ST_IDLE;
                            halted_q <= 1'b0;
                            ce_q     <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign cpu_ce    = ce_q;
    assign cpu_rst_n = rst_n_q;
    assign state     = state_q;
    assign halted    = halted_q;
    assign step_cnt  = cnt_q;

endmodule
